instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/mips_loader_pkg.sv | 21 ++
 rtl/byte_assembler.sv | 70 +++++++
 rtl/instruction_loader.sv | 192 +++++++++++++++++++
 tb/tb_instruction_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared definitions for the instruction loader.
//   loader_state_e : FSM state encoding (CHECK exists only with LOADER_CHECKSUM_EN)
//   HALT_WORD      : program terminator word, written and then ends the load
//   BYTE_W         : width of one stream byte
// Optional feature macro: LOADER_CHECKSUM_EN.
package mips_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    StCheck = 3'd2,
`endif
    StDone  = 3'd3,
    StError = 3'd4
  } loader_state_e;

endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs an LSB-first byte stream into SIZE-bit words.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : restart assembly at byte index 0
//   accept_i      : byte_i is taken this cycle
//   byte_i        : stream byte
//   word_valid_o  : one-cycle registered pulse, word_o holds a completed word
//   word_o        : last completed word (registered)
module byte_assembler
  import mips_loader_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_valid_o,
  output logic [SIZE-1:0]   word_o
);

  localparam int unsigned NumBytes = SIZE / BYTE_W;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  logic [IdxW-1:0] idx_q, idx_d;
  logic [SIZE-1:0] lane_q, lane_d;
  logic [SIZE-1:0] word_q, word_d;
  logic            valid_q, valid_d;

  // Bytes enter at the top and shift down, so after NumBytes accepts the
  // first (least significant) byte sits in lane 0.
  always_comb begin
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      idx_d  = '0;
      lane_d = '0;
    end else if (accept_i) begin
      lane_d = {byte_i, lane_q[SIZE-1:BYTE_W]};
      if (idx_q == IdxW'(NumBytes - 1)) begin
        idx_d   = '0;
        word_d  = lane_d;
        valid_d = 1'b1;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: loads a program from a byte stream into instruction
// memory while stalling the pipeline.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_start         : one-cycle load request (honoured in IDLE/DONE/ERROR)
//   i_byte_valid    : i_byte carries a program byte
//   i_byte          : program byte, LSB of each word first
//   o_byte_ready    : a byte is accepted this cycle when valid
//   o_imem_we       : instruction memory write strobe
//   o_imem_addr     : word write address
//   o_imem_data     : assembled word
//   o_stall         : pipeline stall request
//   o_done          : program loaded
//   o_error         : overflow or checksum failure
//   o_count         : number of words written
// Optional feature macro: LOADER_CHECKSUM_EN (running XOR checksum byte after HALT).
module instruction_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned SIZE            = 32,
  parameter int unsigned MAX_INSTRUCTION = 10,
  parameter int unsigned ADDR_W          = $clog2(MAX_INSTRUCTION)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_byte_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]   o_imem_data,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_count
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic            word_valid;
  logic [SIZE-1:0] word;
  logic            byte_fire;
  logic            start_load;
  logic            wr_fire;
  logic            is_halt;
  logic            last_addr;
  logic            asm_accept;

  assign byte_fire  = i_byte_valid & o_byte_ready;
  assign start_load = i_start &
                      ((state_q == StIdle) | (state_q == StDone) | (state_q == StError));
  assign wr_fire    = word_valid & (state_q == StLoad);
  assign is_halt    = (word == SIZE'(HALT_WORD));
  assign last_addr  = (addr_q == ADDR_W'(MAX_INSTRUCTION - 1));
  // A byte arriving in the HALT write cycle is not program data: it is the
  // checksum byte (checksum build) or trailing garbage (default build).
  assign asm_accept = byte_fire & (state_q == StLoad) & ~(wr_fire & is_halt);

  byte_assembler #(
    .SIZE (SIZE)
  ) u_byte_assembler (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_load),
    .accept_i     (asm_accept),
    .byte_i       (i_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_load) begin
      csum_d = '0;
    end else if (asm_accept) begin
      csum_d = csum_q ^ i_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Address / word counter.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (start_load) begin
      addr_d  = '0;
      count_d = '0;
    end else if (wr_fire) begin
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (i_start) state_d = StLoad;
      end
      StLoad: begin
        if (wr_fire) begin
          if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
            // Back-to-back checksum byte lands in the HALT write cycle.
            if (byte_fire) begin
              state_d = (i_byte == csum_q) ? StDone : StError;
            end else begin
              state_d = StCheck;
            end
`else
            state_d = StDone;
`endif
          end else if (last_addr) begin
            state_d = StError;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (byte_fire) state_d = (i_byte == csum_q) ? StDone : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_stall      = 1'b0;
    o_byte_ready = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    unique case (state_q)
      StLoad: begin
        o_stall      = 1'b1;
        o_byte_ready = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        o_stall      = 1'b1;
        o_byte_ready = 1'b1;
      end
`endif
      StDone: o_done = 1'b1;
      StError: begin
        o_error = 1'b1;
        o_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_imem_we   = wr_fire;
  assign o_imem_addr = addr_q;
  assign o_imem_data = word;
  assign o_count     = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  localparam int unsigned SIZE   = 32;
  localparam int unsigned MAXI   = 10;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic              i_byte_valid = 1'b0;
  logic [7:0]        i_byte = 8'h00;
  logic              o_byte_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [SIZE-1:0]   o_imem_data;
  logic              o_stall;
  logic              o_done;
  logic              o_error;
  logic [ADDR_W:0]   o_count;

  instruction_loader #(
    .SIZE            (SIZE),
    .MAX_INSTRUCTION (MAXI),
    .ADDR_W          (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_data  (o_imem_data),
    .o_stall      (o_stall),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE-1:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] tb_csum  = 8'h00;
  logic       prev_we  = 1'b0;

  // Write monitor: every strobe must match the next queued expectation and
  // be exactly one cycle wide.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_we <= 1'b0;
    end else begin
      if (o_imem_we) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                   o_imem_addr, o_imem_data);
        end else begin
          e = exp_q.pop_front();
          if (o_imem_addr !== e.addr || o_imem_data !== e.data) begin
            n_fail++;
            $display("FAIL imem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     o_imem_addr, o_imem_data, e.addr, e.data);
          end
        end
        n_checks++;
        if (prev_we) begin
          n_fail++;
          $display("FAIL we_width: got we high two cycles, expected one");
        end
      end
      prev_we <= o_imem_we;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    i_byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b, input bit gap);
    i_byte_valid = 1'b1;
    i_byte       = b;
    tb_csum      = tb_csum ^ b;
    @(negedge clk);
    if (gap) idle(1);
  endtask

  task automatic send_word(input int addr, input logic [31:0] w, input bit gap);
    logic [31:0] v;
    v = w;
    exp_q.push_back('{addr: ADDR_W'(addr), data: w});
    for (int k = 0; k < 4; k++) put(v[8*k +: 8], gap);
  endtask

  task automatic start();
    i_byte_valid = 1'b0;
    i_start      = 1'b1;
    tb_csum      = 8'h00;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Checksum byte after HALT, sent immediately behind the last HALT byte.
  task automatic end_prog();
`ifdef LOADER_CHECKSUM_EN
    i_byte_valid = 1'b1;
    i_byte       = tb_csum;
    @(negedge clk);
`endif
    idle(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(o_imem_we),    32'h0);
    check({tag, "_stall"}, 32'(o_stall),      32'h0);
    check({tag, "_done"},  32'(o_done),       32'h0);
    check({tag, "_error"}, 32'(o_error),      32'h0);
    check({tag, "_count"}, 32'(o_count),      32'h0);
    check({tag, "_addr"},  32'(o_imem_addr),  32'h0);
    check({tag, "_data"},  o_imem_data,       32'h0);
    check({tag, "_ready"}, 32'(o_byte_ready), 32'h0);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(o_stall), 32'h0);

    // Basic program: one instruction then HALT.
    start();
    check("load_stall", 32'(o_stall), 32'h1);
    check("load_ready", 32'(o_byte_ready), 32'h1);
    send_word(0, 32'h2001_0013, 1'b0);
    send_word(1, 32'hFFFF_FFFF, 1'b0);
    end_prog();
    check("basic_done",  32'(o_done),  32'h1);
    check("basic_count", 32'(o_count), 32'h2);
    check("basic_stall", 32'(o_stall), 32'h0);
    check("basic_ready", 32'(o_byte_ready), 32'h0);

    // Restart from DONE; i_start mid-load must be ignored.
    start();
    check("restart_count", 32'(o_count), 32'h0);
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h4433_2211});
    put(8'h11, 1'b0);
    put(8'h22, 1'b0);
    i_start = 1'b1;
    put(8'h33, 1'b0);
    i_start = 1'b0;
    put(8'h44, 1'b0);
    send_word(1, 32'hFFFF_FFFF, 1'b0);
    end_prog();
    check("midstart_done",  32'(o_done),  32'h1);
    check("midstart_count", 32'(o_count), 32'h2);

    // Gapped byte_valid.
    start();
    send_word(0, 32'h0A0B_0C0D, 1'b1);
    send_word(1, 32'h1234_5678, 1'b1);
    send_word(2, 32'hFFFF_FFFF, 1'b1);
    end_prog();
    check("gap_done",  32'(o_done),  32'h1);
    check("gap_count", 32'(o_count), 32'h3);

    // Reset mid-word after one completed write.
    start();
    send_word(0, 32'h0102_0304, 1'b0);
    put(8'h55, 1'b0);
    put(8'h66, 1'b0);
    i_byte_valid = 1'b0;
    idle(1);
    check("pre_rst_count", 32'(o_count), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start();
    send_word(0, 32'hDDCC_BBAA, 1'b0);
    send_word(1, 32'hFFFF_FFFF, 1'b0);
    end_prog();
    check("postrst_done",  32'(o_done),  32'h1);
    check("postrst_count", 32'(o_count), 32'h2);

    // Overflow: MAXI non-HALT words.
    start();
    for (int i = 0; i < int'(MAXI); i++) send_word(i, 32'h1000_0000 + 32'(i), 1'b0);
    idle(3);
    check("ovf_error", 32'(o_error), 32'h1);
    check("ovf_stall", 32'(o_stall), 32'h1);
    check("ovf_done",  32'(o_done),  32'h0);
    check("ovf_ready", 32'(o_byte_ready), 32'h0);
    check("ovf_count", 32'(o_count), 32'(MAXI));
    for (int k = 0; k < 4; k++) put(8'h77, 1'b0);
    idle(3);
    check("ovf_count_hold", 32'(o_count), 32'(MAXI));

    // HALT at the last address is a legal end.
    start();
    for (int i = 0; i < int'(MAXI) - 1; i++) send_word(i, 32'h2000_0000 + 32'(i), 1'b0);
    send_word(MAXI - 1, 32'hFFFF_FFFF, 1'b0);
    end_prog();
    check("lasthalt_done",  32'(o_done),  32'h1);
    check("lasthalt_error", 32'(o_error), 32'h0);
    check("lasthalt_count", 32'(o_count), 32'(MAXI));

`ifdef LOADER_CHECKSUM_EN
    // Explicit checksum bytes: 0x32 is correct for this stream, 0x00 is not.
    start();
    send_word(0, 32'h2001_0013, 1'b0);
    send_word(1, 32'hFFFF_FFFF, 1'b0);
    idle(2);
    put(8'h32, 1'b0);
    idle(2);
    check("csum_ok_done",  32'(o_done),  32'h1);
    check("csum_ok_error", 32'(o_error), 32'h0);
    start();
    send_word(0, 32'h2001_0013, 1'b0);
    send_word(1, 32'hFFFF_FFFF, 1'b0);
    idle(2);
    put(8'h00, 1'b0);
    idle(2);
    check("csum_bad_error", 32'(o_error), 32'h1);
    check("csum_bad_done",  32'(o_done),  32'h0);
`endif

    idle(2);
    check("pending_writes", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
